// File: rtl/pe_pkg.sv
// Shared constants and lane packing helper for the vector processing element.
package pe_pkg;

    localparam int FP_WIDTH = 32;

    localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_WIDTH-1:0] FP_ONE  = 32'h3F80_0000;

    // Bit offset of lane `lane` inside a packed multi-lane operand bus.
    function automatic int unsigned lane_lsb(input int unsigned lane);
        return lane * FP_WIDTH;
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// Single-precision adder: subnormals flush to zero, round to nearest even.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        ovf
);
    logic [31:0]        x;
    logic [31:0]        y;
    logic [7:0]         d;
    logic [26:0]        mx;
    logic [26:0]        my;
    logic [26:0]        sh;
    logic               lost;
    logic [27:0]        s_raw;
    logic [26:0]        sn;
    logic [4:0]         lz;
    logic signed [9:0]  ex;
    logic [23:0]        rnd;

    function automatic logic [4:0] lzc(input logic [26:0] v);
        lzc = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc = 5'(26 - i);
    endfunction

    always_comb begin
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d    = x[30:23] - y[30:23];
        mx   = {1'b1, x[22:0], 3'b000};
        my   = {1'b1, y[22:0], 3'b000};
        lost = |(my & ((27'd1 << d) - 27'd1));
        sh   = (my >> d) | {26'd0, lost};
        ex   = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) s_raw = {1'b0, mx} + {1'b0, sh};
        else                s_raw = {1'b0, mx} - {1'b0, sh};
        lz = 5'd0;
        if (s_raw[27]) begin
            sn = {s_raw[27:2], s_raw[1] | s_raw[0]};
            ex = ex + 10'sd1;
        end else begin
            lz = lzc(s_raw[26:0]);
            sn = s_raw[26:0] << lz;
            ex = ex - $signed({5'd0, lz});
        end
        rnd = {1'b0, sn[25:3]} + {23'd0, sn[2] & (sn[1] | sn[0] | sn[3])};
        if (rnd[23]) ex = ex + 10'sd1;

        ovf = 1'b0;
        if (y[30:23] == 8'h00)      s = x;
        else if (x[30:23] == 8'hFF) s = x;
        else if (!sn[26])           s = 32'd0;
        else if (ex >= 10'sd255) begin
            s   = {x[31], 8'hFF, 23'd0};
            ovf = 1'b1;
        end
        else if (ex <= 10'sd0)      s = {x[31], 31'd0};
        else                        s = {x[31], ex[7:0], rnd[22:0]};
    end
endmodule

// File: rtl/multiplier_32bit.sv
// Single-precision multiplier: subnormals flush to zero, round to nearest even.
module multiplier_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p,
    output logic        ovf
);
    logic               sgn;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [47:0]        mp;
    logic signed [9:0]  ex;
    logic [22:0]        man;
    logic               g;
    logic               st;
    logic [23:0]        rnd;

    always_comb begin
        sgn = a[31] ^ b[31];
        ea  = a[30:23];
        eb  = b[30:23];
        mp  = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        ex  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (mp[47]) begin
            man = mp[46:24];
            g   = mp[23];
            st  = |mp[22:0];
            ex  = ex + 10'sd1;
        end else begin
            man = mp[45:23];
            g   = mp[22];
            st  = |mp[21:0];
        end
        rnd = {1'b0, man} + {23'd0, g & (st | man[0])};
        if (rnd[23]) ex = ex + 10'sd1;

        ovf = 1'b0;
        if (ea == 8'h00 || eb == 8'h00)      p = {sgn, 31'd0};
        else if (ea == 8'hFF || eb == 8'hFF) p = {sgn, 8'hFF, (ea == 8'hFF) ? a[22:0] : b[22:0]};
        else if (ex >= 10'sd255) begin
            p   = {sgn, 8'hFF, 23'd0};
            ovf = 1'b1;
        end
        else if (ex <= 10'sd0)               p = {sgn, 31'd0};
        else                                 p = {sgn, ex[7:0], rnd[22:0]};
    end
endmodule

// File: rtl/pe_lane.sv
// One MAC lane: operand register, multiply, product register, accumulate.
module pe_lane
    import pe_pkg::*;
(
    input  logic                clk,
    input  logic                clr_n,
    input  logic                adv,
    input  logic                ld_p0,
    input  logic                vld_p1,
    input  logic                vld_p2,
    input  logic                start_p2,
    input  logic [FP_WIDTH-1:0] a_p0,
    input  logic [FP_WIDTH-1:0] b_p0,
    output logic [FP_WIDTH-1:0] acc_nxt,
    output logic                ovf_nxt
);
    logic [FP_WIDTH-1:0] a_p1;
    logic [FP_WIDTH-1:0] b_p1;
    logic [FP_WIDTH-1:0] prod_p1;
    logic                movf_p1;
    logic [FP_WIDTH-1:0] prod_p2;
    logic                movf_p2;
    logic [FP_WIDTH-1:0] acc_p3;
    logic                ovf_p3;
    logic [FP_WIDTH-1:0] sum_p2;
    logic                aovf_p2;

    multiplier_32bit u_mul (.a(a_p1), .b(b_p1), .p(prod_p1), .ovf(movf_p1));
    adder_32bit      u_add (.a(acc_p3), .b(prod_p2), .s(sum_p2), .ovf(aovf_p2));

    assign acc_nxt = start_p2 ? prod_p2 : sum_p2;
    assign ovf_nxt = start_p2 ? movf_p2 : (ovf_p3 | movf_p2 | aovf_p2);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_p1    <= '0;
            b_p1    <= '0;
            prod_p2 <= '0;
            movf_p2 <= 1'b0;
            acc_p3  <= '0;
            ovf_p3  <= 1'b0;
        end else if (adv) begin
            // S1: operand capture
            if (ld_p0) begin
                a_p1 <= a_p0;
                b_p1 <= b_p0;
            end
            // S2: product capture
            if (vld_p1) begin
                prod_p2 <= prod_p1;
                movf_p2 <= movf_p1;
            end
            // S3: accumulate
            if (vld_p2) begin
                acc_p3 <= acc_nxt;
                ovf_p3 <= ovf_nxt;
            end
        end
    end
endmodule

// File: rtl/pe_vec_stream.sv
// Multi-lane flow-controlled FP dot-product engine with a held result register.
module pe_vec_stream
    import pe_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_start,
    input  logic                        in_last,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*ACC_WIDTH-1:0]  out_c,
    output logic [LANES-1:0]            out_ovf,
    output logic [CNT_WIDTH-1:0]        out_count
);
    if (DATA_WIDTH != FP_WIDTH || ACC_WIDTH != DATA_WIDTH) begin : g_width_chk
        $error("pe_vec_stream: DATA_WIDTH and ACC_WIDTH must both be 32");
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                       adv;
    logic                       vld_p1, start_p1, last_p1;
    logic                       vld_p2, start_p2, last_p2;
    logic [CNT_WIDTH-1:0]       cnt_p3;
    logic [CNT_WIDTH-1:0]       cnt_nxt;
    logic [LANES*ACC_WIDTH-1:0] acc_nxt;
    logic [LANES-1:0]           ovf_nxt;

    // Only a held, unconsumed result can stall the pipe.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign cnt_nxt  = start_p2 ? CNT_WIDTH'(1) : sat_inc(cnt_p3);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane u_lane (
            .clk      (clk),
            .clr_n    (clr_n),
            .adv      (adv),
            .ld_p0    (in_valid),
            .vld_p1   (vld_p1),
            .vld_p2   (vld_p2),
            .start_p2 (start_p2),
            .a_p0     (in_a[lane_lsb(i) +: FP_WIDTH]),
            .b_p0     (in_b[lane_lsb(i) +: FP_WIDTH]),
            .acc_nxt  (acc_nxt[lane_lsb(i) +: FP_WIDTH]),
            .ovf_nxt  (ovf_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vld_p1    <= 1'b0;
            start_p1  <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            start_p2  <= 1'b0;
            last_p2   <= 1'b0;
            cnt_p3    <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            out_ovf   <= '0;
            out_count <= '0;
        end else begin
            if (adv) begin
                // S1: control capture, framing bits qualified by valid
                vld_p1   <= in_valid;
                start_p1 <= in_valid & in_start;
                last_p1  <= in_valid & in_last;
                // S2: control follows the product
                vld_p2   <= vld_p1;
                start_p2 <= start_p1;
                last_p2  <= last_p1;
                // S3: term count and result register
                if (vld_p2) cnt_p3 <= cnt_nxt;
            end
            if (adv && vld_p2 && last_p2) begin
                out_valid <= 1'b1;
                out_c     <= acc_nxt;
                out_ovf   <= ovf_nxt;
                out_count <= cnt_nxt;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pe_vec_stream.md
# pe_vec_stream

Multi-lane, flow-controlled successor to the single-lane processing element. LANES independent 32-bit floating-point multiply-accumulate lanes share one control stream (start/last framing) and one valid/ready handshake on each side. Completed dot products are held in a result register until the consumer takes them, and the pipeline stalls under backpressure. Each result carries a per-lane sticky overflow flag and a term count. The block sits between the operand-streaming logic and the result collector in the matrix multiplier.

## Interface
- LANES, 4: number of parallel MAC lanes (≥1).
- DATA_WIDTH, 32: operand width. Fixed at 32 by the FP units; any other value is a elaboration error.
- ACC_WIDTH, 32: accumulator/result width. Must equal DATA_WIDTH.
- CNT_WIDTH, 16: width of the term counter.
- clk  in  1  clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_start  in  1  beat is the first term of a new sequence.
- in_last  in  1  beat is the final term of the sequence.
- in_a  in  LANES*DATA_WIDTH  lane i operand A at bits [i*32 +: 32].
- in_b  in  LANES*DATA_WIDTH  lane i operand B, same packing.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out_c  out  LANES*ACC_WIDTH  per-lane dot-product result.
- out_ovf  out  LANES  per-lane sticky overflow (mul or add) over the sequence.
- out_count  out  CNT_WIDTH  number of terms in the sequence, saturating.

## Operation
- Beat accepted when in_valid && in_ready. Control bits are ignored when in_valid=0.
- stall = out_valid && !out_ready. in_ready = !stall. While stalled, every pipeline register (S1, S2, accumulators, counters) holds its value.
- S1: register operands and control per lane.
- S2: register the product from multiplier_32bit plus the mul overflow.
- S3, valid beat, start=1: acc ← product, ovf ← mul_ovf, cnt ← 1.
- S3, valid beat, start=0: acc ← adder_32bit(acc, product), ovf ← ovf | mul_ovf | add_ovf, cnt ← cnt+1, saturating at 2^CNT_WIDTH−1.
- A continuation beat with no prior start accumulates onto the current acc. This is legal and is not flagged.
- S3, last=1: in the same edge, load out_c/out_ovf/out_count with the new acc/ovf/cnt values and set out_valid.
- start=1 and last=1 on one beat: single-term result, out_c = product, out_count = 1.
- out_valid clears on out_valid && out_ready, unless a new last beat completes on the same edge. In that case the result register reloads and out_valid stays 1.
- S3 with an empty beat: acc holds.

## Timing
- Reset values: in_ready=1, out_valid=0, out_c=0, out_ovf=0, out_count=0. All pipeline registers are 0 and all valid bits are 0.
- Latency: a last beat accepted at edge E0 is visible in the result register after edge E2 (out_valid high in cycle E2+1), provided no stall occurs.
- Stall cycles add 1:1 to the latency.
- Throughput: 1 beat/cycle while out_ready=1. Back-to-back single-term sequences produce a result every cycle.
- out_c, out_ovf and out_count are stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. No other comb paths exist from input to output.
- Reset asserted mid-sequence or with a result pending: all state clears immediately. The pending result is lost, and partial sums do not resume.

## Structure
- Package pe_pkg holds FP_WIDTH=32, the constants FP_ZERO=32'h0000_0000 and FP_ONE=32'h3F80_0000 (used by the bench), and the lane packing helper function.
- Sub-module pe_lane covers one lane: the S1 operand registers, multiplier_32bit, the S2 product/ovf register, adder_32bit, the accumulator and the sticky ovf. It takes a shared advance enable (!stall) and the shared control bits.
- The top level holds the control pipeline (valid/start/last through S1/S2), the term counter, the result register and the handshake, plus a generate loop over pe_lane.

## Test plan
- Single lane, two beats {1.0×2.0 start}, {2.0×2.0 last} (0x3F800000·0x40000000, 0x40000000·0x40000000), out_ready=1 → after E2 of the last beat: out_c=0x40C00000 (6.0), out_count=2, out_ovf=0.
- LANES=4, one start+last beat with lane i: a=i+1.0, b=2.0 → out_c lanes = {2.0, 4.0, 6.0, 8.0} = {0x40000000, 0x40800000, 0x40C00000, 0x41000000}, out_count=1.
- Backpressure: hold out_ready=0 with a result pending and stream 3 more beats → in_ready=0 after the first beat stalls. The pending out_c stays unchanged. After out_ready rises, the next result appears with no lost or duplicated beat.
- Overflow: beat 0x7F000000×0x7F000000 start, then 1.0×1.0 last → out_ovf[lane]=1. The next sequence, 1.0×1.0 start+last, gives out_ovf=0.
- Consume and reload on the same edge: out_ready=1 while a second last beat completes → out_valid stays 1 and out_c updates to the second result.
- Reset mid-sequence: clr_n low for 1 cycle after 2 of 4 beats → all outputs 0 and in_ready=1. A fresh 1.0×3.0 start+last beat gives 0x40400000.
